// File: rtl/spw_light_ctrl_out.sv
// spw_light_ctrl_out
//   Avalon-MM slave output port that drives SpaceWire link-control lines
//   (link_start, auto_start, link_disable, FIFO flush strobes, ...).
//
//   Register map (address):
//     0 DATA  : write loads out_port, read returns out_port
//     1 SET   : write ORs writedata into out_port, read returns 0
//     2 CLEAR : write clears the bits set in writedata, read returns 0
//     3 PULSE : write 1 to bit i starts (or retriggers) a PULSE_CYCLES-long
//               strobe on pulse_port[i]; read returns the active-pulse mask
//
//   Ports:
//     clk        : system clock, all logic on the rising edge
//     reset      : synchronous, active-high reset
//     chipselect : slave select
//     write_n    : active-low write strobe (write = chipselect & ~write_n)
//     address    : register select (2 bits)
//     writedata  : 32-bit write data, bits above WIDTH ignored
//     readdata   : registered read data, zero-extended above WIDTH
//     out_port   : level control outputs (WIDTH bits)
//     pulse_port : strobe control outputs (WIDTH bits)

module spw_light_ctrl_out #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               PULSE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [1:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] pulse_port
);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLEAR = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  // Counter wide enough to hold PULSE_CYCLES itself.
  localparam int            CW        = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYCLES);

  // Counter step that stops at zero instead of wrapping.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
    logic [CW-1:0] r;
    if (c == '0) r = '0;
    else         r = c - CW'(1);
    return r;
  endfunction

  // Zero-extend a WIDTH-bit value onto the 32-bit bus (also covers WIDTH=32).
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r            = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] pulse_ld;
  logic [31:0]      rd_nxt;
  logic [CW-1:0]    cnt [WIDTH];

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];

  // Bits of writedata above WIDTH are intentionally ignored.
  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic unused_wd_hi;
      assign unused_wd_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  // Level register next value: load, atomic set or atomic clear.
  always_comb begin
    out_nxt = out_port;
    if (wr) begin
      case (address)
        ADDR_DATA:  out_nxt = wd;
        ADDR_SET:   out_nxt = out_port | wd;
        ADDR_CLEAR: out_nxt = out_port & ~wd;
        default:    out_nxt = out_port;
      endcase
    end
  end

  // Per-bit pulse trigger mask; 0 bits leave a running pulse alone.
  always_comb begin
    pulse_ld = '0;
    if (wr && (address == ADDR_PULSE)) pulse_ld = wd;
  end

  always_ff @(posedge clk) begin
    if (reset) out_port <= RESET_VALUE;
    else       out_port <= out_nxt;
  end

  // A load always wins over the decrement, which gives retrigger for free.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset)            cnt[i] <= '0;
      else if (pulse_ld[i]) cnt[i] <= PULSE_LD;
      else                  cnt[i] <= sat_dec(cnt[i]);
    end
  end

  // Strobe is high while its counter is nonzero; cnt is registered state,
  // so pulse_port never follows writedata combinationally.
  always_comb begin
    pulse_port = '0;
    for (int i = 0; i < WIDTH; i++) pulse_port[i] = |cnt[i];
  end

  // Read mux; readdata is updated every cycle regardless of chipselect.
  always_comb begin
    rd_nxt = '0;
    case (address)
      ADDR_DATA:  rd_nxt = zext(out_port);
      ADDR_PULSE: rd_nxt = zext(pulse_port);
      default:    rd_nxt = '0;
    endcase
  end

  // ---- read data register stage ----
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_nxt;
  end

endmodule

// File: tb/tb_spw_light_ctrl_out.sv
module tb_spw_light_ctrl_out;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic        chipselect1;
  logic        write_n;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata1;
  logic [7:0]  out_port;
  logic [7:0]  out_port1;
  logic [7:0]  pulse_port;
  logic [7:0]  pulse_port1;

  spw_light_ctrl_out #(.WIDTH(8), .RESET_VALUE(8'h05), .PULSE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write_n(write_n),
    .address(address), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .pulse_port(pulse_port)
  );

  spw_light_ctrl_out #(.WIDTH(8), .RESET_VALUE(8'h00), .PULSE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .chipselect(chipselect1), .write_n(write_n),
    .address(address), .writedata(writedata), .readdata(readdata1),
    .out_port(out_port1), .pulse_port(pulse_port1)
  );

  localparam int S_OUT = 0, S_PULSE = 1, S_RD = 2, S_PULSE1 = 3, S_RD1 = 4;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   ncyc  = 0;
  int   ncmp  = 0;
  int   nfail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pick(input int sel);
    logic [31:0] r;
    r = '0;
    case (sel)
      S_OUT:    r = {24'h0, out_port};
      S_PULSE:  r = {24'h0, pulse_port};
      S_RD:     r = readdata;
      S_PULSE1: r = {24'h0, pulse_port1};
      S_RD1:    r = readdata1;
      default:  r = 'x;
    endcase
    return r;
  endfunction

  // Scoreboard consumer: compares every due expectation at the falling edge.
  always @(negedge clk) begin
    logic [31:0] obs;
    ncyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= ncyc) begin
        obs = pick(sb[i].sel);
        ncmp++;
        assert (sb[i].cyc == ncyc && obs === sb[i].val) else begin
          nfail++;
          $error("FAIL %s @cyc %0d: observed %h expected %h", sb[i].tag, ncyc, obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic rst_i, input logic cs_i, input logic cs1_i,
                       input logic wn_i, input logic [1:0] a_i, input logic [31:0] d_i);
    reset       = rst_i;
    chipselect  = cs_i;
    chipselect1 = cs1_i;
    write_n     = wn_i;
    address     = a_i;
    writedata   = d_i;
  endtask

  task automatic idle(input logic [1:0] a_i);
    drive(1'b0, 1'b0, 1'b0, 1'b1, a_i, 32'h0);
  endtask

  // Expectation k falling edges from now (k >= 1).
  task automatic sb_push(input int k, input int sel, input logic [31:0] v, input string tag);
    exp_t e;
    e.cyc = ncyc + k;
    e.sel = sel;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
    tick();

    // Reset state
    sb_push(1, S_OUT,    32'h05, "rst_out");
    sb_push(1, S_PULSE,  32'h00, "rst_pulse");
    sb_push(1, S_RD,     32'h00, "rst_rd");
    sb_push(1, S_RD1,    32'h00, "rst_rd1");
    sb_push(1, S_PULSE1, 32'h00, "rst_pulse1");
    tick();

    // 1: DATA write and readback
    idle(2'd0);
    sb_push(1, S_OUT, 32'h05, "t1_out_before");
    sb_push(1, S_RD,  32'h05, "t1_rd_reset_val");
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'hFFFF_FFA3);
    sb_push(1, S_OUT, 32'hA3, "t1_out_after");
    sb_push(1, S_RD,  32'h05, "t1_rd_old");
    tick();
    idle(2'd0);
    sb_push(1, S_RD, 32'h0000_00A3, "t1_rd_new");
    tick();

    // 2: set and clear
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0F);
    sb_push(1, S_OUT, 32'h0F, "t2_load");
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h30);
    sb_push(1, S_OUT, 32'h3F, "t2_set");
    sb_push(1, S_RD,  32'h00, "t2_rd_set");
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h03);
    sb_push(1, S_OUT, 32'h3C, "t2_clear");
    sb_push(1, S_RD,  32'h00, "t2_rd_clear");
    tick();
    idle(2'd0);
    sb_push(1, S_RD, 32'h3C, "t2_rd_data");
    tick();

    // 3: pulse width
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'h81);
    for (int k = 1; k <= 4; k++) sb_push(k, S_PULSE, 32'h81, "t3_pulse_hi");
    sb_push(5, S_PULSE, 32'h00, "t3_pulse_lo");
    sb_push(1, S_RD, 32'h00, "t3_rd_before");
    for (int k = 2; k <= 5; k++) sb_push(k, S_RD, 32'h81, "t3_rd_mask");
    sb_push(6, S_RD, 32'h00, "t3_rd_done");
    sb_push(3, S_OUT, 32'h3C, "t3_out_kept");
    tick();
    for (int k = 0; k < 6; k++) begin idle(2'd3); tick(); end

    // 4: retrigger and write-0
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'h01);
    sb_push(1, S_PULSE, 32'h01, "t4_p1");
    sb_push(2, S_PULSE, 32'h01, "t4_p2");
    sb_push(3, S_PULSE, 32'h03, "t4_p3");
    sb_push(4, S_PULSE, 32'h03, "t4_p4");
    sb_push(5, S_PULSE, 32'h03, "t4_p5");
    sb_push(6, S_PULSE, 32'h03, "t4_p6");
    sb_push(7, S_PULSE, 32'h01, "t4_p7");
    sb_push(8, S_PULSE, 32'h00, "t4_p8");
    tick();
    idle(2'd3);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'h02);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'h01);
    tick();
    for (int k = 0; k < 5; k++) begin idle(2'd3); tick(); end

    // 5A: unqualified writes
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'hAA);
    sb_push(1, S_OUT, 32'h3C, "t5_cs0");
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'hC3);
    sb_push(1, S_OUT, 32'h3C, "t5_wn1");
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 32'h40);
    sb_push(1, S_PULSE, 32'h00, "t5_wn1_pulse");
    tick();

    // 5B: reset priority during a pulse
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'h04);
    sb_push(1, S_PULSE, 32'h04, "t5_pulse_on");
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'hFF);
    sb_push(1, S_PULSE, 32'h00, "t5_rst_pulse");
    sb_push(1, S_OUT,   32'h05, "t5_rst_out");
    sb_push(1, S_RD,    32'h00, "t5_rst_rd");
    tick();
    idle(2'd0);
    sb_push(1, S_OUT,   32'h05, "t5_post_out");
    sb_push(1, S_PULSE, 32'h00, "t5_post_pulse");
    tick();

    // 6: PULSE_CYCLES=1, back-to-back writes
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 32'h10);
    sb_push(1, S_PULSE1, 32'h10, "t6_p1");
    sb_push(2, S_PULSE1, 32'h10, "t6_p2");
    sb_push(3, S_PULSE1, 32'h00, "t6_p3");
    sb_push(1, S_RD1, 32'h00, "t6_rd1");
    sb_push(2, S_RD1, 32'h10, "t6_rd2");
    sb_push(3, S_RD1, 32'h10, "t6_rd3");
    sb_push(4, S_RD1, 32'h00, "t6_rd4");
    sb_push(2, S_OUT, 32'h05, "t6_dut_out");
    sb_push(2, S_PULSE, 32'h00, "t6_dut_pulse");
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 32'h10);
    tick();
    for (int k = 0; k < 4; k++) begin idle(2'd3); tick(); end

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    ncmp++;
    assert (sb.size() == 0) else begin
      nfail++;
      $error("FAIL drain: observed %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/spw_light_ctrl_out.md
# spw_light_ctrl_out

Avalon-MM slave output port for the spw_light SpaceWire system: it drives link-control lines toward the SpaceWire core. Examples are link_start, auto_start, link_disable and the FIFO flush strobes. It is the write-side counterpart of the read-only status input ports on the same bus. It provides a level register with atomic bit set/clear, plus a self-timed pulse register for strobe-type controls. All outputs are registered in the single clk domain.

## Interface
Parameters:
- WIDTH, 8, number of level and pulse output bits (1..32)
- RESET_VALUE, 0, value loaded into out_port on reset (WIDTH bits)
- PULSE_CYCLES, 4, high time of each pulse_port bit in clk cycles (1..255)

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- reset  input  1  synchronous, active-high reset
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe; a write occurs only when chipselect=1 and write_n=0
- address  input  2  register select: 0=DATA, 1=SET, 2=CLEAR, 3=PULSE
- writedata  input  32  write data; bits [31:WIDTH] are ignored
- readdata  output  32  registered read data, zero-extended above WIDTH
- out_port  output  WIDTH  level control outputs
- pulse_port  output  WIDTH  strobe control outputs

## Operation
- **DATA (0):**
  - A write loads out_port <= writedata[WIDTH-1:0].
  - A read returns out_port.
- **SET (1):**
  - A write performs out_port <= out_port | writedata; bits written as 0 are unchanged.
  - A read returns 0.
- **CLEAR (2):**
  - A write performs out_port <= out_port & ~writedata.
  - A read returns 0.
- **PULSE (3):**
  - Each bit i has a down-counter cnt[i] of width clog2(PULSE_CYCLES+1).
  - Writing 1 to bit i loads cnt[i] <= PULSE_CYCLES.
  - When no load occurs, a nonzero counter decrements by 1 per cycle.
  - pulse_port[i] = (cnt[i] != 0). It is driven from a register, not combinationally from writedata.
  - Writing 0 to bit i has no effect: a pulse in progress continues.
  - Writing 1 to a bit that is already pulsing reloads its counter (retrigger), extending the pulse to PULSE_CYCLES cycles from the new write.
  - A read returns pulse_port (the mask of active pulses).
- **readdata:**
  - Updated every cycle: readdata <= zero-extend(mux(address)).
  - The update is independent of chipselect and write_n; the bus master qualifies reads.
- Writes with chipselect=0, or with write_n=1, have no effect on any register.
- **Reset (synchronous, reset=1 sampled at an edge):**
  - out_port <= RESET_VALUE
  - all cnt <= 0, so pulse_port <= 0
  - readdata <= 0
  - Reset has priority over a simultaneous write.
  - A reset applied mid-pulse ends the pulse at that edge.

## Timing
- Write latency: a write sampled at edge N changes out_port or pulse_port at edge N, so the new value is visible in cycle N+1.
- Pulse width: pulse_port[i] is high for exactly PULSE_CYCLES consecutive cycles, starting in the cycle after the write edge.
- Retrigger: a write to PULSE at edge M while a pulse is active keeps pulse_port[i] high through cycle M+PULSE_CYCLES. There is no low glitch.
- Read latency: 1 cycle. readdata in cycle N+1 reflects the address and register state sampled at edge N.
- Read after write to the same register returns the new value:
  - write at edge N, hold address, readdata valid in cycle N+2;
  - a read sampled at edge N returns the old value.
- Back-to-back writes on consecutive cycles are all honoured; there are no wait states.
- Reset values: readdata=0, out_port=RESET_VALUE, pulse_port=0.

## Test plan
1. **Reset, then DATA write and readback:**
   - Stimulus: WIDTH=8, RESET_VALUE=8'h05. Release reset, then write DATA=0xFFFF_FFA3.
   - Required: out_port=8'h05 until the write edge, then 8'hA3. Reading DATA returns 32'h0000_00A3.
2. **Set and clear:**
   - Stimulus: from out_port=8'h0F, write SET=8'h30, then on the next cycle write CLEAR=8'h03.
   - Required: out_port=8'h3F, then 8'h3C. Reading SET or CLEAR returns 0.
3. **Pulse width:**
   - Stimulus: PULSE_CYCLES=4; write PULSE=8'h81.
   - Required: pulse_port=8'h81 for exactly 4 cycles, then 8'h00. Reading PULSE during the pulse returns 32'h81.
4. **Retrigger and write-0:**
   - Stimulus: write PULSE=8'h01, then 2 cycles later write PULSE=8'h02, then 1 cycle later write PULSE=8'h01.
   - Required: bit0 stays high continuously for 7 cycles in total. Bit1 is high for 4 cycles, unaffected by the bit0 rewrite.
5. **Qualification and reset priority:**
   - Stimulus A: write DATA with chipselect=0.
   - Required A: out_port is unchanged.
   - Stimulus B: during an active pulse, assert reset=1 together with a DATA write of 8'hFF.
   - Required B: pulse_port=0, out_port=RESET_VALUE and readdata=0 at that edge.
6. **PULSE_CYCLES=1 boundary:**
   - Stimulus: write PULSE=8'h10 on two consecutive cycles.
   - Required: bit4 is high for exactly 2 cycles with no gap.
